// File: rtl/adc_sensor_reader.sv
// -----------------------------------------------------------------------------
// adc_sensor_reader
//
// SPI master for an ADC128S022-style 8-channel 12-bit ADC (16-clock frames).
// It scans the left, middle and right line-sensor channels continuously and
// holds the latest conversion of each. A one-cycle Sample_Valid pulse marks
// the update of RightSensor, which completes a left/middle/right set.
//
// The ADC answers each frame with the conversion for the address sent in the
// previous frame, so the first frame after reset or after IDLE is a dummy.
// Frame timing: CS_SETUP (CLK_DIV) + 16 SCLK periods (32*CLK_DIV) +
// CS_HOLD (2*CLK_DIV) = 35*CLK_DIV Clk_50 cycles.
//
// Ports:
//   Clk_50        system clock (50 MHz)
//   Rst_n         asynchronous active-low reset
//   Enable        1 = scan continuously, 0 = stop after the current frame
//   Adc_Dout      serial data from the ADC, MSB first
//   Adc_Cs_N      ADC chip select, active low (registered)
//   Adc_Sclk      ADC serial clock, idles high (registered)
//   Adc_Din       serial channel address to the ADC (registered)
//   LeftSensor    latest left-channel conversion
//   MiddleSensor  latest middle-channel conversion
//   RightSensor   latest right-channel conversion
//   Sample_Valid  one-cycle pulse when RightSensor updates
//   Busy          1 while a frame is in progress
// -----------------------------------------------------------------------------
module adc_sensor_reader #(
   parameter int unsigned CLK_DIV   = 13,    // SCLK half-period in Clk_50 cycles, 2..255
   parameter logic [2:0]  LEFT_CH   = 3'd0,
   parameter logic [2:0]  MIDDLE_CH = 3'd1,
   parameter logic [2:0]  RIGHT_CH  = 3'd2
) (
   input  logic        Clk_50,
   input  logic        Rst_n,
   input  logic        Enable,
   input  logic        Adc_Dout,
   output logic        Adc_Cs_N,
   output logic        Adc_Sclk,
   output logic        Adc_Din,
   output logic [11:0] LeftSensor,
   output logic [11:0] MiddleSensor,
   output logic [11:0] RightSensor,
   output logic        Sample_Valid,
   output logic        Busy
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] CS_SETUP = 2'd1;
   localparam logic [1:0] SHIFT    = 2'd2;
   localparam logic [1:0] CS_HOLD  = 2'd3;

   // Channel pointer positions in scan order.
   localparam logic [1:0] PTR_L = 2'd0;
   localparam logic [1:0] PTR_M = 2'd1;
   localparam logic [1:0] PTR_R = 2'd2;

   // Hold needs 2*CLK_DIV, up to 510, hence the 9-bit divider.
   localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
   localparam logic [8:0] HOLD_LAST = 9'(2 * CLK_DIV - 1);

   logic [1:0]  state;
   logic [1:0]  ptr;
   logic [8:0]  div_cnt;
   logic [3:0]  bit_cnt;       // SCLK period number k within SHIFT
   logic [11:0] shift_reg;
   logic [2:0]  prev_addr;     // address whose conversion arrives in this frame
   logic        prev_valid;    // 0 during the dummy frame
   logic [2:0]  addr;
   logic [15:0] tx_word;

   assign addr    = (ptr == PTR_L) ? LEFT_CH :
                    (ptr == PTR_M) ? MIDDLE_CH : RIGHT_CH;
   assign tx_word = {2'b00, addr, 11'b0};
   assign Busy    = (state != IDLE);

   // NOTE: every register below is sequential state, so it is assigned with
   // non-blocking (<=) only; reads within the block see the pre-edge values.
   always_ff @(posedge Clk_50 or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= IDLE;
         ptr          <= PTR_L;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         prev_addr    <= '0;
         prev_valid   <= 1'b0;
         Adc_Cs_N     <= 1'b1;
         Adc_Sclk     <= 1'b1;
         Adc_Din      <= 1'b0;
         LeftSensor   <= '0;
         MiddleSensor <= '0;
         RightSensor  <= '0;
         Sample_Valid <= 1'b0;
      end else begin
         Sample_Valid <= 1'b0;

         case (state)
            IDLE: begin
               if (Enable) begin
                  // A fresh scan starts at LEFT with a dummy frame.
                  state      <= CS_SETUP;
                  Adc_Cs_N   <= 1'b0;
                  div_cnt    <= '0;
                  ptr        <= PTR_L;
                  prev_valid <= 1'b0;
               end
            end

            CS_SETUP: begin
               if (div_cnt == HALF_LAST) begin
                  // Falling edge into the low half of period k=0.
                  state    <= SHIFT;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  Adc_Sclk <= 1'b0;
                  Adc_Din  <= tx_word[15];
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end

            SHIFT: begin
               if (div_cnt == HALF_LAST) begin
                  div_cnt <= '0;
                  if (!Adc_Sclk) begin
                     // Rising edge: capture data bits; k=0..3 are leading zeros.
                     Adc_Sclk <= 1'b1;
                     if (bit_cnt >= 4'd4) begin
                        shift_reg <= {shift_reg[10:0], Adc_Dout};
                     end
                  end else if (bit_cnt == 4'd15) begin
                     state    <= CS_HOLD;
                     Adc_Cs_N <= 1'b1;
                     if (prev_valid) begin
                        if (prev_addr == LEFT_CH) begin
                           LeftSensor <= shift_reg;
                        end else if (prev_addr == MIDDLE_CH) begin
                           MiddleSensor <= shift_reg;
                        end else if (prev_addr == RIGHT_CH) begin
                           RightSensor  <= shift_reg;
                           Sample_Valid <= 1'b1;
                        end
                     end
                     prev_addr  <= addr;
                     prev_valid <= 1'b1;
                     ptr        <= (ptr == PTR_R) ? PTR_L : ptr + 2'd1;
                  end else begin
                     // Falling edge: Adc_Din only changes here.
                     Adc_Sclk <= 1'b0;
                     bit_cnt  <= bit_cnt + 4'd1;
                     Adc_Din  <= tx_word[4'd14 - bit_cnt];
                  end
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end

            CS_HOLD: begin
               if (div_cnt == HOLD_LAST) begin
                  div_cnt <= '0;
                  if (Enable) begin
                     state    <= CS_SETUP;
                     Adc_Cs_N <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  div_cnt <= div_cnt + 9'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_sensor_reader.sv
// -----------------------------------------------------------------------------
// tb_adc_sensor_reader
//
// Self-checking bench for adc_sensor_reader at CLK_DIV=2. A behavioural
// ADC model answers each frame with the channel addressed in the previous
// frame. Expected sensor values follow from the scan order (frame n returns
// the channel sent in frame n-1, order L,M,R) and the model's channel data.
// -----------------------------------------------------------------------------
module tb_adc_sensor_reader;

   localparam int CLK_DIV = 2;
   localparam int FRAME   = 35 * CLK_DIV;
   localparam int CS_LOW  = 33 * CLK_DIV;

   logic        Clk_50   = 1'b0;
   logic        Rst_n    = 1'b0;
   logic        Enable   = 1'b0;
   logic        Adc_Dout = 1'b0;
   logic        Adc_Cs_N;
   logic        Adc_Sclk;
   logic        Adc_Din;
   logic [11:0] LeftSensor;
   logic [11:0] MiddleSensor;
   logic [11:0] RightSensor;
   logic        Sample_Valid;
   logic        Busy;

   always #10 Clk_50 = ~Clk_50;

   adc_sensor_reader #(
      .CLK_DIV   (CLK_DIV),
      .LEFT_CH   (3'd0),
      .MIDDLE_CH (3'd1),
      .RIGHT_CH  (3'd2)
   ) dut (
      .Clk_50       (Clk_50),
      .Rst_n        (Rst_n),
      .Enable       (Enable),
      .Adc_Dout     (Adc_Dout),
      .Adc_Cs_N     (Adc_Cs_N),
      .Adc_Sclk     (Adc_Sclk),
      .Adc_Din      (Adc_Din),
      .LeftSensor   (LeftSensor),
      .MiddleSensor (MiddleSensor),
      .RightSensor  (RightSensor),
      .Sample_Valid (Sample_Valid),
      .Busy         (Busy)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   always @(posedge Clk_50) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural ADC model ----------------
   logic [11:0] ch_data [8];
   bit          force_lead  = 1'b0;   // drive 1 on Dout during k=0..3
   int          m_k         = 0;
   logic [15:0] m_word      = '0;
   logic [15:0] m_din       = '0;     // Din word seen this frame
   logic [2:0]  m_prev_addr = '0;

   always @(negedge Adc_Cs_N) begin
      m_k    = 0;
      m_din  = '0;
      m_word = {4'b0000, ch_data[m_prev_addr]};
   end

   always @(negedge Adc_Sclk) begin
      if (!Adc_Cs_N && m_k < 16)
         Adc_Dout = (force_lead && m_k < 4) ? 1'b1 : m_word[15 - m_k];
   end

   always @(posedge Adc_Sclk) begin
      if (!Adc_Cs_N) begin
         m_din = {m_din[14:0], Adc_Din};
         m_k++;
      end
   end

   always @(posedge Adc_Cs_N) m_prev_addr = m_din[13:11];

   // ---------------- reference expectations ----------------
   logic [2:0]  seq_ch [3];
   logic [11:0] exp_s  [3];
   int          last_fall = 0;

   task automatic check_sensors(input string tag);
      check({tag, "_left"},   32'(LeftSensor),   32'(exp_s[0]));
      check({tag, "_middle"}, 32'(MiddleSensor), 32'(exp_s[1]));
      check({tag, "_right"},  32'(RightSensor),  32'(exp_s[2]));
   endtask

   // Follows one frame (index n since leaving IDLE) to its first CS_HOLD cycle.
   // drop_k >= 0 deasserts Enable during SCLK period k=drop_k.
   task automatic frame_check(input int n, input int drop_k);
      int t, low, rises, pos;
      bit sv_seen;
      logic prev_sclk;
      t = 0;
      while (Adc_Cs_N === 1'b1 && t < 400) begin
         @(negedge Clk_50);
         t++;
      end
      if (Adc_Cs_N !== 1'b0) begin
         check("cs_fall_timeout", 32'(Adc_Cs_N), 32'd0);
         return;
      end
      if (n > 0) check("frame_period", 32'(cyc - last_fall), 32'(FRAME));
      last_fall = cyc;
      low = 0; rises = 0; sv_seen = 1'b0;
      prev_sclk = Adc_Sclk;
      while (Adc_Cs_N === 1'b0 && low < 200) begin
         low++;
         if (Adc_Sclk && !prev_sclk) rises++;
         prev_sclk = Adc_Sclk;
         if (Sample_Valid) sv_seen = 1'b1;
         if (drop_k >= 0 && rises == drop_k + 1) Enable = 1'b0;
         @(negedge Clk_50);
      end
      check("cs_low_cycles", 32'(low), 32'(CS_LOW));
      check("sclk_rises", 32'(rises), 32'd16);
      check("sv_inside_frame", 32'(sv_seen), 32'd0);
      check("din_word", 32'(m_din), 32'({2'b00, seq_ch[n % 3], 11'b0}));
      check("busy_in_hold", 32'(Busy), 32'd1);
      // Frame n delivers the channel addressed in frame n-1.
      if (n >= 1) begin
         pos = (n - 1) % 3;
         exp_s[pos] = ch_data[seq_ch[pos]];
      end
      check("sample_valid", 32'(Sample_Valid), 32'(n >= 3 && n % 3 == 0));
      check_sensors("frame_end");
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (Busy !== 1'b0 && t < 200) begin
         @(negedge Clk_50);
         t++;
      end
      check("idle_reached", 32'(Busy), 32'd0);
   endtask

   // Watches an idle bus: no CS, no SCLK edges, no pulse, outputs held.
   task automatic idle_watch(input int cycles, input string tag);
      bit cs_low, sclk_low, sv_hi, out_chg;
      cs_low = 0; sclk_low = 0; sv_hi = 0; out_chg = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge Clk_50);
         if (Adc_Cs_N !== 1'b1) cs_low = 1;
         if (Adc_Sclk !== 1'b1) sclk_low = 1;
         if (Sample_Valid !== 1'b0) sv_hi = 1;
         if (LeftSensor !== exp_s[0] || MiddleSensor !== exp_s[1] || RightSensor !== exp_s[2])
            out_chg = 1;
      end
      check({tag, "_cs_low"},   32'(cs_low),   32'd0);
      check({tag, "_sclk_low"}, 32'(sclk_low), 32'd0);
      check({tag, "_sv"},       32'(sv_hi),    32'd0);
      check({tag, "_out_held"}, 32'(out_chg),  32'd0);
   endtask

   typedef struct {
      logic [11:0] l, m, r;
      bit          lead;
      int          frames;
      logic [11:0] el, em, er;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int t, rises;
      logic prev_sclk;

      vecs[0] = '{12'd1000,  12'd600,   12'd4095,  1'b0, 7, 12'd1000,  12'd600,   12'd4095};
      vecs[1] = '{12'h000,   12'h000,   12'h800,   1'b1, 4, 12'h000,   12'h000,   12'h800};
      vecs[2] = '{12'hFFF,   12'h000,   12'hABC,   1'b1, 4, 12'hFFF,   12'h000,   12'hABC};
      vecs[3] = '{12'h555,   12'hAAA,   12'h001,   1'b0, 4, 12'h555,   12'hAAA,   12'h001};
      vecs[4] = '{12'h800,   12'h7FF,   12'h000,   1'b0, 4, 12'h800,   12'h7FF,   12'h000};

      seq_ch[0] = 3'd0; seq_ch[1] = 3'd1; seq_ch[2] = 3'd2;
      for (int i = 0; i < 3; i++) exp_s[i] = '0;
      for (int i = 0; i < 8; i++) ch_data[i] = 12'(i * 37 + 5);

      // ---- reset state and idle with Enable low ----
      repeat (4) @(negedge Clk_50);
      check("rst_cs_n", 32'(Adc_Cs_N), 32'd1);
      check("rst_sclk", 32'(Adc_Sclk), 32'd1);
      check("rst_din",  32'(Adc_Din),  32'd0);
      check("rst_sv",   32'(Sample_Valid), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check_sensors("rst");
      Rst_n = 1'b1;
      idle_watch(100, "idle_disabled");

      // ---- table-driven vectors ----
      for (int v = 0; v < 5; v++) begin
         ch_data[0] = vecs[v].l;
         ch_data[1] = vecs[v].m;
         ch_data[2] = vecs[v].r;
         force_lead = vecs[v].lead;
         Enable = 1'b1;
         for (int n = 0; n < vecs[v].frames; n++) begin
            frame_check(n, -1);
            if (n == 3) begin
               check("vec_left",   32'(LeftSensor),   32'(vecs[v].el));
               check("vec_middle", 32'(MiddleSensor), 32'(vecs[v].em));
               check("vec_right",  32'(RightSensor),  32'(vecs[v].er));
            end
         end
         Enable = 1'b0;
         wait_idle();
         force_lead = 1'b0;
      end

      // ---- randomized continuous scan, then drop Enable in an M frame ----
      Enable = 1'b1;
      for (int n = 0; n < 11; n++) begin
         frame_check(n, (n == 10) ? 7 : -1);
         for (int c = 0; c < 8; c++) ch_data[c] = 12'($urandom_range(0, 4095));
      end
      check("drop_enable_low", 32'(Enable), 32'd0);
      wait_idle();
      idle_watch(100, "after_drop");

      // ---- re-enable: dummy frame first, pulse 4 frames later ----
      Enable = 1'b1;
      for (int n = 0; n < 4; n++) begin
         frame_check(n, -1);
         for (int c = 0; c < 8; c++) ch_data[c] = 12'($urandom_range(0, 4095));
      end

      // ---- asynchronous reset at SHIFT k=10 ----
      t = 0;
      while (Adc_Cs_N === 1'b1 && t < 400) begin
         @(negedge Clk_50);
         t++;
      end
      rises = 0;
      prev_sclk = Adc_Sclk;
      t = 0;
      while (rises < 11 && t < 200) begin
         @(negedge Clk_50);
         if (Adc_Sclk && !prev_sclk) rises++;
         prev_sclk = Adc_Sclk;
         t++;
      end
      check("reach_k10", 32'(rises), 32'd11);
      check("k10_cs_low", 32'(Adc_Cs_N), 32'd0);
      Rst_n = 1'b0;
      #1;
      check("async_cs_n", 32'(Adc_Cs_N), 32'd1);
      check("async_sclk", 32'(Adc_Sclk), 32'd1);
      check("async_sv",   32'(Sample_Valid), 32'd0);
      check("async_busy", 32'(Busy), 32'd0);
      for (int i = 0; i < 3; i++) exp_s[i] = '0;
      check_sensors("async_rst");
      Enable = 1'b0;
      repeat (3) @(negedge Clk_50);
      Rst_n = 1'b1;
      idle_watch(30, "post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/adc_sensor_reader.md
Name: adc_sensor_reader

Overview:
SPI master for the on-board 8-channel 12-bit ADC (ADC128S022-style, 16-clock frames) that produces the three line-sensor words LeftSensor, MiddleSensor and RightSensor consumed by the locomotion controller. It scans the left, middle and right channels continuously on Clk_50 and holds the latest conversion of each in a register. After every complete left/middle/right set it pulses Sample_Valid.

Parameters:
CLK_DIV, 13, SCLK half-period in Clk_50 cycles (13 gives 1.923 MHz SCLK); legal range 2..255
LEFT_CH, 3'd0, ADC channel address of the left sensor
MIDDLE_CH, 3'd1, ADC channel address of the middle sensor
RIGHT_CH, 3'd2, ADC channel address of the right sensor

Ports:
Clk_50  input  1  system clock, 50 MHz
Rst_n  input  1  asynchronous active-low reset
Enable  input  1  1 = scan continuously; 0 = stop after the current frame
Adc_Dout  input  1  serial data from ADC, MSB first
Adc_Cs_N  output  1  ADC chip select, active low
Adc_Sclk  output  1  ADC serial clock, idles high
Adc_Din  output  1  serial channel address to ADC
LeftSensor  output  12  latest left-channel conversion
MiddleSensor  output  12  latest middle-channel conversion
RightSensor  output  12  latest right-channel conversion
Sample_Valid  output  1  one-cycle pulse when RightSensor updates, completing a set
Busy  output  1  1 while a frame is in progress (Adc_Cs_N low or in CS_HOLD)

Behaviour:
- Reset (asynchronous, Rst_n=0): Adc_Cs_N=1, Adc_Sclk=1, Adc_Din=0, all sensor outputs 12'd0, Sample_Valid=0, Busy=0, FSM=IDLE, channel pointer=LEFT, prev_valid=0. Reset mid-frame aborts the frame immediately and no output register updates.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD.
- IDLE: if Enable=1, go to CS_SETUP on the next cycle and drive Adc_Cs_N=0.
- CS_SETUP: Adc_Cs_N=0, Adc_Sclk=1, held for CLK_DIV cycles, then enter SHIFT.
- SHIFT: 16 SCLK periods, numbered k=0..15. Each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - Adc_Din changes only on the falling edge (entry to the low half).
  - Adc_Din carries the 16-bit word {2'b00, addr[2:0], 11'b0} MSB first, so the address bits appear in periods k=2,3,4.
  - Adc_Dout is sampled on the Clk_50 cycle where Adc_Sclk rises, for k=4..15 only, and shifted into a 12-bit register MSB first. Samples at k=0..3 are ignored.
  - After the high half of k=15, enter CS_HOLD.
- CS_HOLD: Adc_Cs_N=1, Adc_Sclk=1 for 2*CLK_DIV cycles.
  - On the first CS_HOLD cycle: if prev_valid=1, write the shifted word to the sensor register selected by prev_addr.
  - Sample_Valid=1 on that same cycle only when prev_addr=RIGHT_CH.
  - Then set prev_addr=addr and prev_valid=1, and advance the pointer L→M→R→L.
  - On exit: go to CS_SETUP if Enable=1, otherwise IDLE.
- Frame length is 35*CLK_DIV cycles (455 at the default).
- Pipeline: the ADC returns data for the address sent in the previous frame. The first frame after reset, or after IDLE, is therefore a dummy: its data is discarded (prev_valid=0).
  - Frame sequence from IDLE sends L, M, R, L, ...
  - The first Sample_Valid occurs at the end of frame 3 (the fourth frame); after that it occurs every 3 frames.
- Enable is sampled only in IDLE and at CS_HOLD exit. Deasserting it mid-frame lets the frame complete normally, including the register write.
- Leaving IDLE clears prev_valid, and the pointer restarts at LEFT.
- Sensor outputs change only on the write cycle and hold their value otherwise, including while in IDLE.
- Adc_Sclk, Adc_Cs_N and Adc_Din are registered outputs with no combinational paths.

Test Plan:
1. Reset, then hold Enable=0 for 100 cycles → Adc_Cs_N=1, Adc_Sclk=1, all sensor outputs 0, Sample_Valid never asserted.
2. CLK_DIV=2, Enable=1, single frame → Adc_Cs_N low for exactly 2+64 cycles with 16 SCLK rising edges. Adc_Din word must be 0x0000 for L, 0x0800 for M, 0x1000 for R frames. Frame period is 70 cycles.
3. ADC model returns ch0=1000 (0x3E8), ch1=600 (0x258), ch2=4095 (0xFFF), run 7 frames → first Sample_Valid at end of frame 3 with Left=1000, Middle=600, Right=4095. Second pulse comes exactly 3 frames later, and outputs never take a dummy-frame value.
4. Drop Enable at SHIFT k=7 of an M frame → frame completes, Left updated, Adc_Cs_N stays 1 with no further SCLK edges. Outputs hold; re-enable gives a dummy frame first and the next Sample_Valid 4 frames later.
5. Assert Rst_n=0 at SHIFT k=10 → Adc_Cs_N=1 and Adc_Sclk=1 in the same cycle (asynchronous), outputs 0, no Sample_Valid.
6. Model returns 0x800 on ch2 only while Adc_Dout is forced 1 during k=0..3 → RightSensor=0x800, showing the leading bits are ignored.
